// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the MAC dot-product sequencer.
// Optional feature macro: MAC_SAT_EN (saturating accumulator; used in mac_acc_unit).
package mac_pkg;

   localparam int DATA_W  = 4;
   localparam int ACC_W   = 10;
   localparam int LEN_W   = 4;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mac_acc_unit.sv
// mac_acc_unit: unsigned multiply, ACC_W+1 bit add, sticky overflow and accumulator register.
// Optional feature macro: MAC_SAT_EN -- when defined the accumulator saturates at all-ones
// instead of wrapping. Once saturated, later adds either overflow again or add zero, so the
// value stays pinned for the rest of the command.
module mac_acc_unit #(
   parameter int DATA_W = mac_pkg::DATA_W,
   parameter int ACC_W  = mac_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   logic [2*DATA_W-1:0] prod;
   logic [ACC_W:0]      sum;

   // product and one-bit-wider sum so the carry out is the overflow indicator
   always_comb begin
      prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
      sum  = {1'b0, acc} + (ACC_W+1)'(prod);
   end

   // accumulator and sticky overflow; clear wins over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (en) begin
         ovf <= ovf | sum[ACC_W];
`ifdef MAC_SAT_EN
         if (sum[ACC_W]) begin
            acc <= '1;
         end else begin
            acc <= sum[ACC_W-1:0];
         end
`else
         acc <= sum[ACC_W-1:0];
`endif
      end
   end

endmodule

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: command / operand / result handshake sequencer around mac_acc_unit.
// Optional feature macro: MAC_SAT_EN (passed through to mac_acc_unit).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command; last result still shown
// RUN   | op_ready high, consuming operand pairs until cnt reaches 1
// DONE  | res_valid high, result held until res_ready
module mac_dot_sequencer
   import mac_pkg::*;
#(
   parameter int DATA_W = mac_pkg::DATA_W,
   parameter int ACC_W  = mac_pkg::ACC_W,
   parameter int LEN_W  = mac_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_ovf,
   output logic              busy
);

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic             acc_clr;
   logic             acc_en;

   // handshake strobes; cmd_ready/op_ready are registered state decodes
   always_comb begin
      acc_clr = cmd_ready & cmd_valid;
      acc_en  = op_ready & op_valid;
   end

   mac_acc_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .a     (op_a),
      .b     (op_b),
      .acc   (res_data),
      .ovf   (res_ovf)
   );

   // sequencing FSM with registered Moore handshake outputs and down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                  if (cmd_len != '0) begin
                     cnt      <= cmd_len;
                     state    <= RUN;
                     op_ready <= 1'b1;
                  end else begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (op_valid) begin
                  cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     state     <= DONE;
                     op_ready  <= 1'b0;
                     res_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               op_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: directed self-checking bench for mac_dot_sequencer.
// Optional feature macro: MAC_SAT_EN (changes the expected saturated result).
module tb_mac_dot_sequencer;
   import mac_pkg::*;

   logic                     clk;
   logic                     rst_n;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [mac_pkg::LEN_W-1:0]  cmd_len;
   logic                     op_valid;
   logic                     op_ready;
   logic [mac_pkg::DATA_W-1:0] op_a;
   logic [mac_pkg::DATA_W-1:0] op_b;
   logic                     res_valid;
   logic                     res_ready;
   logic [mac_pkg::ACC_W-1:0]  res_data;
   logic                     res_ovf;
   logic                     busy;

   int n_cmp;
   int n_err;

   mac_dot_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_ovf   (res_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one active edge, then settle before driving/sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // finish the result handshake and return to IDLE
   task automatic drain();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL rst_op_ready got=%0b exp=0", op_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
      n_cmp++; if (res_data !== 10'd0) begin n_err++; $display("FAIL rst_res_data got=%0d exp=0", res_data); end
      n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL rst_res_ovf got=%0b exp=0", res_ovf); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      cmd_valid = 1'b1; cmd_len = 4'd3;
      step();
      cmd_valid = 1'b0;
      n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL basic_op_ready got=%0b exp=1", op_ready); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL basic_cmd_ready got=%0b exp=0", cmd_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%0b exp=1", busy); end
      op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
      step();
      step();
      op_a = 4'd2; op_b = 4'd3;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%0b exp=0", res_valid); end
      step();
      op_valid = 1'b0;
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL basic_res_valid got=%0b exp=1", res_valid); end
      n_cmp++; if (res_data !== 10'd456) begin n_err++; $display("FAIL basic_res_data got=%0d exp=456", res_data); end
      n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL basic_res_ovf got=%0b exp=0", res_ovf); end
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL basic_op_ready_done got=%0b exp=0", op_ready); end
      drain();
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_res_valid_idle got=%0b exp=0", res_valid); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_cmd_ready_idle got=%0b exp=1", cmd_ready); end
      n_cmp++; if (res_data !== 10'd456) begin n_err++; $display("FAIL basic_data_kept got=%0d exp=456", res_data); end
   endtask

   task automatic test_overflow();
      logic [mac_pkg::ACC_W-1:0] exp_data;
`ifdef MAC_SAT_EN
      exp_data = mac_pkg::ACC_W'(mac_pkg::ACC_MAX);
`else
      exp_data = 10'd101;
`endif
      cmd_valid = 1'b1; cmd_len = 4'd5;
      step();
      cmd_valid = 1'b0;
      op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
      repeat (5) step();
      op_valid = 1'b0;
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL ovf_res_valid got=%0b exp=1", res_valid); end
      n_cmp++; if (res_data !== exp_data) begin n_err++; $display("FAIL ovf_res_data got=%0d exp=%0d", res_data, exp_data); end
      n_cmp++; if (res_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_res_ovf got=%0b exp=1", res_ovf); end
      drain();
   endtask

   task automatic test_zero_len();
      cmd_valid = 1'b1; cmd_len = 4'd0;
      step();
      cmd_valid = 1'b0;
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL zero_res_valid got=%0b exp=1", res_valid); end
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL zero_op_ready got=%0b exp=0", op_ready); end
      n_cmp++; if (res_data !== 10'd0) begin n_err++; $display("FAIL zero_res_data got=%0d exp=0", res_data); end
      n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL zero_res_ovf got=%0b exp=0", res_ovf); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got=%0b exp=1", busy); end
      step();
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL zero_op_ready_hold got=%0b exp=0", op_ready); end
      drain();
   endtask

   task automatic test_gaps_stall();
      cmd_valid = 1'b1; cmd_len = 4'd2;
      step();
      cmd_valid = 1'b0;
      op_a = 4'd15; op_b = 4'd15;
      repeat (3) step();
      n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL gap_op_ready got=%0b exp=1", op_ready); end
      op_valid = 1'b1; op_a = 4'd3; op_b = 4'd4;
      step();
      op_valid = 1'b0; op_a = 4'd15; op_b = 4'd15;
      repeat (3) step();
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid got=%0b exp=0", res_valid); end
      op_valid = 1'b1; op_a = 4'd5; op_b = 4'd6;
      step();
      op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
      cmd_valid = 1'b1; cmd_len = 4'd1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stall_res_valid[%0d] got=%0b exp=1", i, res_valid); end
         n_cmp++; if (res_data !== 10'd42) begin n_err++; $display("FAIL stall_res_data[%0d] got=%0d exp=42", i, res_data); end
         n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL stall_cmd_ready[%0d] got=%0b exp=0", i, cmd_ready); end
         step();
      end
      op_valid = 1'b0;
      drain();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_done_cmd_ready got=%0b exp=1", cmd_ready); end
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL post_done_op_ready got=%0b exp=0", op_ready); end
      n_cmp++; if (res_data !== 10'd42) begin n_err++; $display("FAIL post_done_data got=%0d exp=42", res_data); end
      step();
      cmd_valid = 1'b0;
      n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL next_cmd_op_ready got=%0b exp=1", op_ready); end
      op_valid = 1'b1; op_a = 4'd1; op_b = 4'd1;
      step();
      op_valid = 1'b0;
      n_cmp++; if (res_data !== 10'd1) begin n_err++; $display("FAIL next_cmd_data got=%0d exp=1", res_data); end
      drain();
   endtask

   task automatic test_reset_abort();
      cmd_valid = 1'b1; cmd_len = 4'd4;
      step();
      cmd_valid = 1'b0;
      op_valid = 1'b1; op_a = 4'd2; op_b = 4'd2;
      repeat (2) step();
      op_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_cmd_ready got=%0b exp=1", cmd_ready); end
      n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL abort_op_ready got=%0b exp=0", op_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL abort_res_valid got=%0b exp=0", res_valid); end
      n_cmp++; if (res_data !== 10'd0) begin n_err++; $display("FAIL abort_res_data got=%0d exp=0", res_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      step();
      rst_n = 1'b1;
      step();
      cmd_valid = 1'b1; cmd_len = 4'd1;
      step();
      cmd_valid = 1'b0;
      op_valid = 1'b1; op_a = 4'd7; op_b = 4'd9;
      step();
      op_valid = 1'b0;
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL abort_new_valid got=%0b exp=1", res_valid); end
      n_cmp++; if (res_data !== 10'd63) begin n_err++; $display("FAIL abort_new_data got=%0d exp=63", res_data); end
      n_cmp++; if (res_ovf !== 1'b0) begin n_err++; $display("FAIL abort_new_ovf got=%0b exp=0", res_ovf); end
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_overflow();
      test_zero_len();
      test_gaps_stall();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
